// File: rtl/red_pitaya_fads_sort_sched.sv
`timescale 1ns / 1ps
// red_pitaya_fads_sort_sched
//
// Sort scheduler between the FADS threshold detector and the sort trigger.
// Every accepted "sort" detection is stamped with the cycle on which it must
// fire (due time), stored in a small FIFO, and released as a fixed-width
// pulse on sort_trig once the free-running timestamp reaches the due time.
// Several droplets may be in flight at once. Pulses never merge: every pulse
// is followed by at least one low cycle.
//
// Ports
//   adc_clk_i, adc_rstn_i   clock, asynchronous active-low reset
//   det_valid_i, det_sort_i detector result strobe and sort decision
//   sort_trig               sort pulse output
//   busy_o                  queue non-empty or scheduler not idle
//   fsm_state               scheduler state (0 idle, 1 wait, 2 fire, 3 gap)
//   sys_*                   system bus slave (registered ack/rdata)
//
// Register map (sys_addr[19:0])
//   0x00 CTRL    bit0 enable, bit1 flush (W1, self-clearing), bit2 clr_cnt (W1)
//   0x04 DELAY   detector-to-junction travel time in cycles
//   0x08 WIDTH   pulse width in cycles (0 behaves as 1)
//   0x0C STATUS  [QAW:0] queue count, bit16 overflow (sticky), bit17 busy
//   0x10 SORTED  0x14 DROPPED  0x18 DETECTED
//
// Bus handshake: a request is a single-cycle sys_wen or sys_ren pulse; the
// slave answers with sys_ack exactly one cycle later, with sys_rdata valid in
// that same ack cycle. There is no back-pressure and no error response.

module red_pitaya_fads_sort_sched #(
  parameter int QAW = 3,
  parameter int TSW = 32
) (
  input  logic        adc_clk_i,
  input  logic        adc_rstn_i,
  input  logic        det_valid_i,
  input  logic        det_sort_i,
  output logic        sort_trig,
  output logic        busy_o,
  output logic [1:0]  fsm_state,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  localparam int DEPTH = 2 ** QAW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIRE = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [TSW-1:0]   ts;
  logic [TSW-1:0]   delay_r, width_r;
  logic [TSW-1:0]   cnt, cnt_nxt, width_eff;
  logic             enable, overflow;
  logic [31:0]      sorted_cnt, dropped_cnt, detected_cnt;

  logic [TSW-1:0]   mem [DEPTH];
  logic [QAW-1:0]   wr_ptr, rd_ptr;
  logic [QAW:0]     count;
  logic             q_empty, q_full;
  logic [TSW-1:0]   head_diff, due;
  logic             head_due;
  logic             push_req, push, drop, pop;

  logic [19:0]      addr;
  logic             ctrl_wr, flush, clr_cnt;
  logic [31:0]      rd_mux;

  // Byte selects and upper address bits are not decoded (full-word access).
  logic unused_bus;
  assign unused_bus = &{1'b0, sys_sel, sys_addr[31:20], sys_wdata};

  assign addr    = sys_addr[19:0];
  assign ctrl_wr = sys_wen && (addr == 20'h00000);
  assign flush   = ctrl_wr && sys_wdata[1];
  assign clr_cnt = ctrl_wr && sys_wdata[2];

  // ---------------------------------------------------------------------------
  // Timestamp and event queue
  // ---------------------------------------------------------------------------
  assign q_empty = (count == '0);
  assign q_full  = (count == (QAW+1)'(DEPTH));

  // Due is taken relative to the timestamp seen on the cycle the entry becomes
  // visible (ts+1), which gives detection-to-pulse latency of DELAY+2 cycles.
  assign due = ts + delay_r + TSW'(1);

  // Wrap-safe comparison: the head is due once ts has reached or passed it,
  // i.e. the modular difference is non-negative.
  assign head_diff = ts - mem[rd_ptr];
  assign head_due  = !q_empty && !head_diff[TSW-1];

  // A detection in the flush cycle is discarded outright; fullness is judged
  // before any pop of the same cycle.
  assign push_req = det_valid_i && det_sort_i && enable && !flush;
  assign push     = push_req && !q_full;
  assign drop     = push_req && q_full;

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      ts <= '0;
    end else begin
      ts <= ts + TSW'(1);
    end
  end

  always_ff @(posedge adc_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= due;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + QAW'(1);
      if (pop)  rd_ptr <= rd_ptr + QAW'(1);
      case ({push, pop})
        2'b10:   count <= count + (QAW+1)'(1);
        2'b01:   count <= count - (QAW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Pulse scheduler
  // ---------------------------------------------------------------------------
  // A due head is launched straight from IDLE, WAIT or GAP so that a late
  // event follows the previous pulse after exactly one low cycle; WAIT is
  // where the scheduler parks while the head is not yet due.
  assign width_eff = (width_r == '0) ? TSW'(1) : width_r;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    case (state)
      S_IDLE, S_WAIT, S_GAP: begin
        if (head_due) begin
          pop       = 1'b1;
          cnt_nxt   = width_eff;
          state_nxt = S_FIRE;
        end else if (!q_empty) begin
          state_nxt = S_WAIT;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FIRE: begin
        if (cnt <= TSW'(1)) begin
          state_nxt = S_GAP;
        end else begin
          cnt_nxt = cnt - TSW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) begin
      pop       = 1'b0;
      state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign sort_trig = (state == S_FIRE);
  assign busy_o    = !q_empty || (state != S_IDLE);
  assign fsm_state = state;

  // ---------------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------------
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      sorted_cnt   <= '0;
      dropped_cnt  <= '0;
      detected_cnt <= '0;
      overflow     <= 1'b0;
    end else if (clr_cnt) begin
      sorted_cnt   <= '0;
      dropped_cnt  <= '0;
      detected_cnt <= '0;
      overflow     <= 1'b0;
    end else begin
      if (det_valid_i) detected_cnt <= detected_cnt + 32'd1;
      if (pop)         sorted_cnt   <= sorted_cnt + 32'd1;
      if (drop) begin
        dropped_cnt <= dropped_cnt + 32'd1;
        overflow    <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Bus registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      enable  <= 1'b0;
      delay_r <= '0;
      width_r <= TSW'(1);
    end else if (sys_wen) begin
      case (addr)
        20'h00000: enable  <= sys_wdata[0];
        20'h00004: delay_r <= sys_wdata[TSW-1:0];
        20'h00008: width_r <= sys_wdata[TSW-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      20'h00000: rd_mux = {31'd0, enable};
      20'h00004: rd_mux = 32'(delay_r);
      20'h00008: rd_mux = 32'(width_r);
      20'h0000C: begin
        rd_mux[QAW:0] = count;
        rd_mux[16]    = overflow;
        rd_mux[17]    = busy_o;
      end
      20'h00010: rd_mux = sorted_cnt;
      20'h00014: rd_mux = dropped_cnt;
      20'h00018: rd_mux = detected_cnt;
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      sys_ack   <= 1'b0;
      sys_rdata <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      if (sys_ren) sys_rdata <= rd_mux;
    end
  end

  assign sys_err = 1'b0;

endmodule

// File: tb/tb_red_pitaya_fads_sort_sched.sv
`timescale 1ns / 1ps
// Bench for red_pitaya_fads_sort_sched. Directed stimulus pushes expected
// pulses (start cycle, width) and expected bus responses into queues; monitor
// processes pop and compare whenever the DUT presents a pulse or an ack.
// A second instance with an 8-bit timestamp exercises the timestamp wrap.

module tb_red_pitaya_fads_sort_sched;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT signals
  logic        det_valid, det_sort;
  logic [31:0] sys_addr, sys_wdata;
  logic [3:0]  sys_sel;
  logic        sys_wen, sys_ren;
  logic        trig, busy, err, ack;
  logic [1:0]  st;
  logic [31:0] rdata;
  logic        trig2, busy2, err2, ack2;
  logic [1:0]  st2;
  logic [31:0] rdata2;

  red_pitaya_fads_sort_sched u_dut (
    .adc_clk_i(clk), .adc_rstn_i(rst_n),
    .det_valid_i(det_valid), .det_sort_i(det_sort),
    .sort_trig(trig), .busy_o(busy), .fsm_state(st),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
    .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(rdata), .sys_err(err), .sys_ack(ack)
  );

  red_pitaya_fads_sort_sched #(.QAW(3), .TSW(8)) u_wrap (
    .adc_clk_i(clk), .adc_rstn_i(rst_n),
    .det_valid_i(det_valid), .det_sort_i(det_sort),
    .sort_trig(trig2), .busy_o(busy2), .fsm_state(st2),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
    .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(rdata2), .sys_err(err2), .sys_ack(ack2)
  );

  // scoreboard state
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_start_q[$];
  logic [31:0] exp_width_q[$];
  logic        exp_isrd_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // pulse monitor (main instance)
  bit in_p = 1'b0;
  int p_start = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_p = 1'b0;
    end else if (trig && !in_p) begin
      in_p    = 1'b1;
      p_start = cyc;
    end else if (!trig && in_p) begin
      in_p = 1'b0;
      if (exp_start_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected pulse: started cycle %0d, none expected", p_start);
      end else begin
        chk("pulse start", p_start, exp_start_q.pop_front());
        chk("pulse width", cyc - p_start, exp_width_q.pop_front());
      end
    end
  end

  // bus monitor
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (exp_isrd_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected ack at cycle %0d", cyc);
      end else begin
        logic        is_rd;
        logic [31:0] a, e;
        is_rd = exp_isrd_q.pop_front();
        a     = exp_addr_q.pop_front();
        e     = exp_q.pop_front();
        if (is_rd) chk($sformatf("read 0x%0h", a), rdata, e);
      end
    end
  end

  // pulse recorder (wrap instance)
  bit t2_prev = 1'b0;
  int t2_st = 0, t2_rise = 0, t2_width = 0, t2_n = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      t2_prev = 1'b0;
    end else begin
      if (trig2 && !t2_prev) t2_st = cyc;
      if (!trig2 && t2_prev) begin
        t2_rise  = t2_st;
        t2_width = cyc - t2_st;
        t2_n++;
      end
      t2_prev = trig2;
    end
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic det(input logic s, output int n);
    det_valid = 1'b1;
    det_sort  = s;
    n         = cyc;
    step();
    det_valid = 1'b0;
    det_sort  = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    sys_addr  = a;
    sys_wdata = d;
    sys_wen   = 1'b1;
    exp_isrd_q.push_back(1'b0);
    exp_addr_q.push_back(a);
    exp_q.push_back(32'd0);
    step();
    sys_wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, input logic [31:0] e);
    sys_addr = a;
    sys_ren  = 1'b1;
    exp_isrd_q.push_back(1'b1);
    exp_addr_q.push_back(a);
    exp_q.push_back(e);
    step();
    sys_ren = 1'b0;
  endtask

  task automatic exp_pulse(input int s, input int w);
    exp_start_q.push_back(s);
    exp_width_q.push_back(w);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " sort_trig"}, trig, 0);
    chk({tag, " busy_o"}, busy, 0);
    chk({tag, " sys_ack"}, ack, 0);
    chk({tag, " sys_rdata"}, rdata, 0);
    chk({tag, " sys_err"}, err, 0);
    chk({tag, " fsm_state"}, st, 0);
  endtask

  task automatic check_reset_regs();
    bus_rd(32'h00, 0);
    bus_rd(32'h04, 0);
    bus_rd(32'h08, 1);
    bus_rd(32'h0C, 0);
    bus_rd(32'h10, 0);
    bus_rd(32'h14, 0);
    bus_rd(32'h18, 0);
  endtask

  // stimulus
  initial begin
    int n, m, r0, p2;
    rst_n     = 1'b0;
    det_valid = 1'b0;
    det_sort  = 1'b0;
    sys_addr  = '0;
    sys_wdata = '0;
    sys_sel   = 4'hF;
    sys_wen   = 1'b0;
    sys_ren   = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    check_reset_regs();

    // single droplet: DELAY=100, WIDTH=20
    bus_wr(32'h00, 1);
    bus_wr(32'h04, 100);
    bus_wr(32'h08, 20);
    det(1'b1, n);
    exp_pulse(n + 102, 20);
    goto_cyc(n + 130);
    bus_rd(32'h10, 1);
    bus_rd(32'h18, 1);
    bus_rd(32'h0C, 0);
    bus_rd(32'h14, 0);

    // two droplets, second one late
    bus_wr(32'h00, 5);
    bus_wr(32'h04, 50);
    bus_wr(32'h08, 30);
    det(1'b1, n);
    exp_pulse(n + 52, 30);
    exp_pulse(n + 83, 30);
    goto_cyc(n + 10);
    det(1'b1, m);
    goto_cyc(n + 60);
    bus_rd(32'h0C, 32'h0002_0001);
    goto_cyc(n + 120);
    bus_rd(32'h10, 2);
    bus_rd(32'h18, 2);

    // overflow: 10 back-to-back detections into an 8-deep queue
    bus_wr(32'h00, 5);
    bus_wr(32'h04, 1000);
    bus_wr(32'h08, 5);
    det(1'b1, n);
    for (int k = 1; k < 10; k++) det(1'b1, m);
    for (int k = 0; k < 8; k++) exp_pulse(n + 1002 + 6 * k, 5);
    bus_rd(32'h0C, 32'h0003_0008);
    bus_rd(32'h14, 2);
    bus_rd(32'h18, 10);
    bus_rd(32'h10, 0);
    goto_cyc(n + 1070);
    bus_rd(32'h10, 8);
    bus_rd(32'h0C, 32'h0001_0000);
    // disabled: detection counted, nothing queued
    bus_wr(32'h00, 0);
    det(1'b1, m);
    bus_rd(32'h0C, 32'h0001_0000);
    bus_rd(32'h18, 11);

    // flush mid-pulse, with a queued event and a detection in the flush cycle
    bus_wr(32'h00, 1);
    bus_wr(32'h04, 10);
    bus_wr(32'h08, 40);
    det(1'b1, n);
    exp_pulse(n + 12, 9);
    goto_cyc(n + 5);
    det(1'b1, m);
    goto_cyc(n + 20);
    det_valid = 1'b1;
    det_sort  = 1'b1;
    bus_wr(32'h00, 3);
    det_valid = 1'b0;
    det_sort  = 1'b0;
    chk("flush sort_trig", trig, 0);
    chk("flush busy_o", busy, 0);
    bus_rd(32'h0C, 32'h0001_0000);
    bus_rd(32'h00, 1);
    det(1'b0, m);
    bus_rd(32'h18, 15);
    bus_rd(32'h10, 9);
    bus_rd(32'h14, 2);
    goto_cyc(cyc + 40);

    // reset, then timestamp wrap on the 8-bit instance
    rst_n = 1'b0;
    #1;
    check_reset_outputs("idle reset");
    step();
    step();
    rst_n = 1'b1;
    r0    = cyc;
    check_reset_regs();
    bus_wr(32'h00, 1);
    bus_wr(32'h04, 20);
    bus_wr(32'h08, 20);
    p2 = t2_n;
    goto_cyc(r0 + 240);
    det(1'b1, n);
    exp_pulse(n + 22, 20);
    goto_cyc(n + 50);
    chk("wrap pulse count", t2_n, p2 + 1);
    chk("wrap pulse start", t2_rise, n + 22);
    chk("wrap pulse width", t2_width, 20);

    // boundaries: DELAY=0 / WIDTH=0, then DELAY=1
    bus_wr(32'h04, 0);
    bus_wr(32'h08, 0);
    det(1'b1, n);
    exp_pulse(n + 2, 1);
    goto_cyc(n + 8);
    bus_wr(32'h04, 1);
    det(1'b1, n);
    exp_pulse(n + 3, 1);
    goto_cyc(n + 8);
    bus_rd(32'h10, 3);
    bus_rd(32'h18, 3);

    // async reset during a pulse
    bus_wr(32'h04, 10);
    bus_wr(32'h08, 40);
    det(1'b1, n);
    goto_cyc(n + 15);
    chk("pre-reset sort_trig", trig, 1);
    goto_cyc(n + 20);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("fire reset");
    step();
    step();
    rst_n = 1'b1;
    check_reset_regs();

    // drain
    for (int i = 0; i < 300 && (exp_start_q.size() != 0 || exp_isrd_q.size() != 0); i++) step();
    chk("pulses outstanding", exp_start_q.size(), 0);
    chk("bus ops outstanding", exp_isrd_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
